// File: rtl/payload_pkg.sv
// Shared definitions for the payload engine sequencer.
//   - 3-bit FSM state encoding (IDLE/CLEAR/SCAN/DRAIN/REPORT)
//   - default widths and drain depth used by the sequencer top
package payload_pkg;

    localparam int unsigned STATE_W = 3;

    localparam logic [STATE_W-1:0] ST_IDLE   = 3'd0;
    localparam logic [STATE_W-1:0] ST_CLEAR  = 3'd1;
    localparam logic [STATE_W-1:0] ST_SCAN   = 3'd2;
    localparam logic [STATE_W-1:0] ST_DRAIN  = 3'd3;
    localparam logic [STATE_W-1:0] ST_REPORT = 3'd4;

    localparam int unsigned DEF_NUM_ENG   = 64;
    localparam int unsigned DEF_IDX_W     = 6;
    localparam int unsigned DEF_LEN_W     = 16;
    localparam int unsigned DEF_DRAIN_CYC = 3;

endpackage

// File: rtl/payload_prio_enc.sv
// Lowest-index priority encoder over the masked engine match vector.
// Ports:
//   vec    in   NUM_ENG  request vector
//   idx_c  out  IDX_W    index of lowest set bit, 0 when none set
//   any_c  out  1        OR of vec
module payload_prio_enc #(
    parameter int unsigned NUM_ENG = 64,
    parameter int unsigned IDX_W   = 6
) (
    input  logic [NUM_ENG-1:0] vec,
    output logic [IDX_W-1:0]   idx_c,
    output logic               any_c
);

    // Scan from the top down so the lowest set bit is the last writer.
    always_comb begin
        idx_c = '0;
        any_c = |vec;
        for (int i = NUM_ENG - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx_c = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/payload_engine_seq.sv
// Per-packet sequencer and match collector for the payload engine array.
// Streams accepted bytes to the engines, waits for the engine pipeline to
// drain after end of packet, then presents a held result.
// Ports:
//   clk, resetn              clock, asynchronous active-low reset
//   s_valid/s_ready/s_data   payload byte stream (s_ready is combinational)
//   s_sop, s_eop             packet delimiters
//   cfg_mask                 per-engine enable, sampled in CLEAR
//   eng_sod, eng_en          engine clear and advance controls
//   eng_byte                 byte to char decoder, valid with eng_en
//   eng_match                engine sticky end-state bits
//   r_valid/r_ready          result handshake, result held until consumed
//   r_hits, r_any, r_first   masked match vector, OR and lowest hit index
//   r_len, r_err             saturating byte count, truncated-by-early-sop flag
module payload_engine_seq
    import payload_pkg::*;
#(
    parameter int unsigned NUM_ENG   = DEF_NUM_ENG,
    parameter int unsigned IDX_W     = DEF_IDX_W,
    parameter int unsigned LEN_W     = DEF_LEN_W,
    parameter int unsigned DRAIN_CYC = DEF_DRAIN_CYC
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               s_valid,
    output logic               s_ready,
    input  logic [7:0]         s_data,
    input  logic               s_sop,
    input  logic               s_eop,
    input  logic [NUM_ENG-1:0] cfg_mask,
    output logic               eng_sod,
    output logic               eng_en,
    output logic [7:0]         eng_byte,
    input  logic [NUM_ENG-1:0] eng_match,
    output logic               r_valid,
    input  logic               r_ready,
    output logic [NUM_ENG-1:0] r_hits,
    output logic               r_any,
    output logic [IDX_W-1:0]   r_first,
    output logic [LEN_W-1:0]   r_len,
    output logic               r_err
);

    localparam int unsigned CNT_W = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DRAIN_CYC - 1);

    logic [STATE_W-1:0] state;
    logic [STATE_W-1:0] state_next;

    logic [NUM_ENG-1:0] mask;
    logic [LEN_W-1:0]   len;
    logic               err;
    logic [CNT_W-1:0]   drain_cnt;

    logic               scan_acc_c;
    logic               early_sop_c;
    logic               drain_done_c;
    logic               len_nz_c;

    logic [NUM_ENG-1:0] hits_c;
    logic [IDX_W-1:0]   first_c;
    logic               any_c;

    assign hits_c = eng_match & mask;

    payload_prio_enc #(
        .NUM_ENG (NUM_ENG),
        .IDX_W   (IDX_W)
    ) u_prio_enc (
        .vec   (hits_c),
        .idx_c (first_c),
        .any_c (any_c)
    );

    // State register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state, stream ready and per-cycle strobes.
    always_comb begin
        state_next   = state;
        s_ready      = 1'b0;
        len_nz_c     = (len != '0);
        // A sop after the first accepted byte truncates the current packet;
        // len is never zero again once a byte has been taken (saturating).
        early_sop_c  = (state == ST_SCAN) && s_valid && s_sop && len_nz_c;
        drain_done_c = (state == ST_DRAIN) && (drain_cnt == CNT_LAST);

        case (state)
            ST_IDLE: begin
                // Stray non-sop bytes are consumed and dropped.
                s_ready = !s_sop;
                if (s_valid && s_sop) begin
                    state_next = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                state_next = ST_SCAN;
            end
            ST_SCAN: begin
                s_ready = !(s_sop && len_nz_c);
                if (early_sop_c) begin
                    state_next = ST_DRAIN;
                end else if (s_valid && s_eop) begin
                    state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (drain_done_c) begin
                    state_next = ST_REPORT;
                end
            end
            ST_REPORT: begin
                if (r_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        scan_acc_c = (state == ST_SCAN) && s_valid && s_ready;
    end

    // Engine controls: one-cycle-delayed copy of each accepted byte.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            eng_sod  <= 1'b1;
            eng_en   <= 1'b0;
            eng_byte <= '0;
        end else begin
            eng_sod <= (state_next == ST_CLEAR);
            eng_en  <= scan_acc_c;
            if (scan_acc_c) begin
                eng_byte <= s_data;
            end
        end
    end

    // Per-packet context: mask, saturating length, error flag.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mask <= '0;
            len  <= '0;
            err  <= 1'b0;
        end else begin
            if (state == ST_CLEAR) begin
                mask <= cfg_mask;
                len  <= '0;
                err  <= 1'b0;
            end else begin
                if (scan_acc_c && (len != '1)) begin
                    len <= len + LEN_W'(1);
                end
                if (early_sop_c) begin
                    err <= 1'b1;
                end
            end
        end
    end

    // Drain counter counts from DRAIN entry. On eop the first DRAIN cycle
    // is the last eng_en cycle; on early sop it is at least one later, which
    // only lengthens the wait.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            drain_cnt <= '0;
        end else if (state != ST_DRAIN) begin
            drain_cnt <= '0;
        end else if (!drain_done_c) begin
            drain_cnt <= drain_cnt + CNT_W'(1);
        end
    end

    // Result registers: captured on the final drain cycle, held until consumed.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_valid <= 1'b0;
            r_hits  <= '0;
            r_any   <= 1'b0;
            r_first <= '0;
            r_len   <= '0;
            r_err   <= 1'b0;
        end else begin
            if (drain_done_c) begin
                r_valid <= 1'b1;
                r_hits  <= hits_c;
                r_any   <= any_c;
                r_first <= first_c;
                r_len   <= len;
                r_err   <= err;
            end else if ((state == ST_REPORT) && r_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_payload_engine_seq.sv
// Directed bench for payload_engine_seq: table of packets plus hand-written
// sequences for stray bytes, early sop and reset mid-packet.
module tb_payload_engine_seq;

    localparam int unsigned NUM_ENG   = 64;
    localparam int unsigned IDX_W     = 6;
    localparam int unsigned LEN_W     = 16;
    localparam int unsigned DRAIN_CYC = 3;

    logic               clk = 1'b0;
    logic               resetn;
    logic               s_valid;
    logic               s_ready;
    logic [7:0]         s_data;
    logic               s_sop;
    logic               s_eop;
    logic [NUM_ENG-1:0] cfg_mask;
    logic               eng_sod;
    logic               eng_en;
    logic [7:0]         eng_byte;
    logic [NUM_ENG-1:0] eng_match;
    logic               r_valid;
    logic               r_ready;
    logic [NUM_ENG-1:0] r_hits;
    logic               r_any;
    logic [IDX_W-1:0]   r_first;
    logic [LEN_W-1:0]   r_len;
    logic               r_err;

    payload_engine_seq #(
        .NUM_ENG   (NUM_ENG),
        .IDX_W     (IDX_W),
        .LEN_W     (LEN_W),
        .DRAIN_CYC (DRAIN_CYC)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
        .s_sop     (s_sop),
        .s_eop     (s_eop),
        .cfg_mask  (cfg_mask),
        .eng_sod   (eng_sod),
        .eng_en    (eng_en),
        .eng_byte  (eng_byte),
        .eng_match (eng_match),
        .r_valid   (r_valid),
        .r_ready   (r_ready),
        .r_hits    (r_hits),
        .r_any     (r_any),
        .r_first   (r_first),
        .r_len     (r_len),
        .r_err     (r_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          nbytes;
        logic [63:0] data;       // byte i at data[8*i +: 8]
        logic [63:0] mask;
        logic [63:0] match;
        int          ready_dly;
        logic [63:0] exp_hits;
        logic        exp_any;
        logic [7:0]  exp_first;
        logic [15:0] exp_len;
    } pkt_vec_t;

    localparam int NVEC = 6;
    pkt_vec_t vecs [NVEC];

    int n_checks = 0;
    int n_errors = 0;

    // Engine-side monitor: bytes delivered and sod cycles seen.
    logic [7:0] cap_q [$];
    int         sod_cnt = 0;

    always @(negedge clk) begin
        if (eng_en) cap_q.push_back(eng_byte);
        if (eng_sod) sod_cnt++;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Present one byte and hold it until the DUT takes it.
    task automatic send_byte(input logic [7:0] d, input logic sop, input logic eop);
        bit ok;
        ok      = 1'b0;
        s_valid = 1'b1;
        s_data  = d;
        s_sop   = sop;
        s_eop   = eop;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (s_ready) begin
                ok = 1'b1;
                break;
            end
        end
        check("byte_accepted", 64'(ok), 64'd1);
        if (ok) begin
            @(posedge clk);
            #1;
        end
        s_valid = 1'b0;
        s_sop   = 1'b0;
        s_eop   = 1'b0;
    endtask

    // Count negedges until r_valid, bounded.
    task automatic wait_result(output int lat);
        lat = 0;
        while (lat < 100) begin
            @(negedge clk);
            lat++;
            if (r_valid) break;
        end
        check("r_valid_seen", 64'(r_valid), 64'd1);
    endtask

    task automatic consume_result();
        r_ready = 1'b1;
        @(posedge clk);
        #1;
        r_ready = 1'b0;
        check("r_valid_clear", 64'(r_valid), 64'd0);
    endtask

    task automatic run_vec(input pkt_vec_t v);
        int lat;
        int sod0;
        bit held;
        cfg_mask  = v.mask;
        eng_match = v.match;
        sod0      = sod_cnt;
        cap_q.delete();
        for (int i = 0; i < v.nbytes; i++) begin
            send_byte(v.data[8*i +: 8], (i == 0), (i == v.nbytes - 1));
        end
        wait_result(lat);
        check("drain_latency", 64'(lat), 64'(DRAIN_CYC + 1));
        check("r_hits", r_hits, v.exp_hits);
        check("r_any", 64'(r_any), 64'(v.exp_any));
        check("r_first", 64'(r_first), 64'(v.exp_first));
        check("r_len", 64'(r_len), 64'(v.exp_len));
        check("r_err", 64'(r_err), 64'd0);
        held = 1'b1;
        for (int k = 0; k < v.ready_dly; k++) begin
            @(negedge clk);
            if (!r_valid) held = 1'b0;
        end
        if (v.ready_dly > 0) check("r_valid_held", 64'(held), 64'd1);
        consume_result();
        check("eng_en_count", 64'(cap_q.size()), 64'(v.nbytes));
        for (int i = 0; i < v.nbytes && i < cap_q.size(); i++) begin
            check("eng_byte", 64'(cap_q[i]), 64'(v.data[8*i +: 8]));
        end
        check("sod_pulses", 64'(sod_cnt - sod0), 64'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int       lat;
        int       sod0;
        bit       ok;
        bit       stray_res;
        pkt_vec_t pv;

        vecs[0] = '{nbytes:6, data:64'h0000_3E74_6168_633C, mask:'1, match:64'h8, ready_dly:0,
                    exp_hits:64'h8, exp_any:1'b1, exp_first:8'd3, exp_len:16'd6};
        vecs[1] = '{nbytes:1, data:64'h41, mask:'1, match:64'h0, ready_dly:10,
                    exp_hits:64'h0, exp_any:1'b0, exp_first:8'd0, exp_len:16'd1};
        vecs[2] = '{nbytes:3, data:64'h11_2233, mask:'1, match:64'h8000_0000_0000_0030, ready_dly:2,
                    exp_hits:64'h8000_0000_0000_0030, exp_any:1'b1, exp_first:8'd4, exp_len:16'd3};
        vecs[3] = '{nbytes:2, data:64'h0A0B, mask:64'hFFFF_FFFF_FFFF_FFF7, match:64'h8, ready_dly:0,
                    exp_hits:64'h0, exp_any:1'b0, exp_first:8'd0, exp_len:16'd2};
        vecs[4] = '{nbytes:4, data:64'hDEAD_BEEF, mask:64'hF000, match:64'hFF00, ready_dly:1,
                    exp_hits:64'hF000, exp_any:1'b1, exp_first:8'd12, exp_len:16'd4};
        vecs[5] = '{nbytes:1, data:64'h5A, mask:'1, match:64'h8000_0000_0000_0000, ready_dly:0,
                    exp_hits:64'h8000_0000_0000_0000, exp_any:1'b1, exp_first:8'd63, exp_len:16'd1};

        resetn    = 1'b0;
        s_valid   = 1'b0;
        s_data    = '0;
        s_sop     = 1'b0;
        s_eop     = 1'b0;
        cfg_mask  = '1;
        eng_match = '0;
        r_ready   = 1'b0;

        // Reset state
        #12;
        check("rst_eng_sod", 64'(eng_sod), 64'd1);
        check("rst_eng_en", 64'(eng_en), 64'd0);
        check("rst_r_valid", 64'(r_valid), 64'd0);
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_eng_sod", 64'(eng_sod), 64'd0);

        // Packet table
        for (int n = 0; n < NVEC; n++) begin
            run_vec(vecs[n]);
        end

        // Stray bytes in IDLE are dropped silently
        sod0 = sod_cnt;
        cap_q.delete();
        send_byte(8'h11, 1'b0, 1'b0);
        send_byte(8'h22, 1'b0, 1'b1);
        send_byte(8'h33, 1'b0, 1'b0);
        stray_res = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (r_valid) stray_res = 1'b1;
        end
        check("stray_eng_en", 64'(cap_q.size()), 64'd0);
        check("stray_result", 64'(stray_res), 64'd0);
        check("stray_sod", 64'(sod_cnt - sod0), 64'd0);

        // Early sop on the 4th byte truncates the packet
        cfg_mask  = '1;
        eng_match = 64'h8;
        cap_q.delete();
        send_byte(8'hA1, 1'b1, 1'b0);
        send_byte(8'hB2, 1'b0, 1'b0);
        send_byte(8'hC3, 1'b0, 1'b0);
        s_valid = 1'b1;
        s_data  = 8'hD4;
        s_sop   = 1'b1;
        s_eop   = 1'b1;
        @(negedge clk);
        check("early_sop_ready", 64'(s_ready), 64'd0);
        wait_result(lat);
        check("early_r_len", 64'(r_len), 64'd3);
        check("early_r_err", 64'(r_err), 64'd1);
        check("early_r_hits", r_hits, 64'h8);
        check("early_eng_en_count", 64'(cap_q.size()), 64'd3);
        consume_result();
        // The held sop byte now opens a fresh single-byte packet
        sod0      = sod_cnt;
        eng_match = '0;
        cap_q.delete();
        ok = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (s_ready) begin
                ok = 1'b1;
                break;
            end
        end
        check("restart_accepted", 64'(ok), 64'd1);
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        s_sop   = 1'b0;
        s_eop   = 1'b0;
        wait_result(lat);
        check("restart_r_len", 64'(r_len), 64'd1);
        check("restart_r_err", 64'(r_err), 64'd0);
        check("restart_r_any", 64'(r_any), 64'd0);
        check("restart_eng_en_count", 64'(cap_q.size()), 64'd1);
        if (cap_q.size() > 0) check("restart_eng_byte", 64'(cap_q[0]), 64'hD4);
        check("restart_sod", 64'(sod_cnt - sod0), 64'd1);
        consume_result();

        // Reset in the middle of SCAN abandons the packet
        cfg_mask  = '1;
        eng_match = 64'h8;
        send_byte(8'h77, 1'b1, 1'b0);
        send_byte(8'h88, 1'b0, 1'b0);
        s_valid = 1'b1;
        s_data  = 8'h99;
        @(posedge clk);
        #2;
        resetn = 1'b0;
        #1;
        check("midrst_eng_sod", 64'(eng_sod), 64'd1);
        check("midrst_eng_en", 64'(eng_en), 64'd0);
        check("midrst_eng_byte", 64'(eng_byte), 64'd0);
        check("midrst_r_valid", 64'(r_valid), 64'd0);
        check("midrst_r_len", 64'(r_len), 64'd0);
        check("midrst_r_first", 64'(r_first), 64'd0);
        s_valid = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk);
        #1;
        pv = '{nbytes:2, data:64'h0102, mask:'1, match:64'h0, ready_dly:0,
               exp_hits:64'h0, exp_any:1'b0, exp_first:8'd0, exp_len:16'd2};
        run_vec(pv);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
